// File: rtl/int_width_converter.sv
// Signed-integer width converter: combinational sign-extension and truncation
// of one input word, plus a registered snapshot of both results and a lossy flag.
module int_width_converter #(
  parameter int IN_W    = 8,
  parameter int EXT_W   = 16,
  parameter int TRUNC_W = 4
) (
  input  logic                       _i_clk,
  input  logic                       _i_rst_n,
  input  logic [IN_W-1:0]            _i_inval,
  output logic [EXT_W+TRUNC_W-1:0]   __output,
  output logic                       _o_lossy,
  output logic [EXT_W+TRUNC_W-1:0]   _o_snap,
  output logic                       _o_snap_lossy
);

  localparam int HEAD_W = IN_W - TRUNC_W + 1;

  // Truncation is lossless only when every bit from the new sign bit up is a copy of it.
  function automatic logic head_mixed(input logic [HEAD_W-1:0] head);
    head_mixed = ~((&head) | ~(|head));
  endfunction

  logic [EXT_W-1:0]           extended_s;
  logic [TRUNC_W-1:0]         truncated_s;
  logic [EXT_W+TRUNC_W-1:0]   snap_r;
  logic                       snap_lossy_r;

  // Combinational conversion; the slice overwrite keeps EXT_W == IN_W legal.
  always_comb begin
    extended_s             = {EXT_W{_i_inval[IN_W-1]}};
    extended_s[IN_W-1:0]   = _i_inval;
    truncated_s            = _i_inval[TRUNC_W-1:0];
    __output               = {extended_s, truncated_s};
    _o_lossy               = head_mixed(_i_inval[IN_W-1:TRUNC_W-1]);
  end

  // Snapshot registers, loaded every cycle, cleared asynchronously by reset.
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      snap_r       <= '0;
      snap_lossy_r <= 1'b0;
    end else begin
      snap_r       <= __output;
      snap_lossy_r <= _o_lossy;
    end
  end

  assign _o_snap       = snap_r;
  assign _o_snap_lossy = snap_lossy_r;

endmodule

// File: tb/tb_int_width_converter.sv
// Directed/scoreboard bench for int_width_converter with default parameters.
module tb_int_width_converter;

  localparam int IN_W    = 8;
  localparam int EXT_W   = 16;
  localparam int TRUNC_W = 4;
  localparam int OUT_W   = EXT_W + TRUNC_W;

  typedef struct {
    logic [OUT_W-1:0] out;
    logic             lossy;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic [IN_W-1:0]  inval;
  logic [OUT_W-1:0] out_c;
  logic             lossy_c;
  logic [OUT_W-1:0] snap;
  logic             snap_lossy;

  int checks;
  int errors;

  exp_t comb_q[$];
  exp_t snap_q[$];

  int_width_converter #(.IN_W(IN_W), .EXT_W(EXT_W), .TRUNC_W(TRUNC_W)) dut (
    ._i_clk        (clk),
    ._i_rst_n      (rst_n),
    ._i_inval      (inval),
    .__output      (out_c),
    ._o_lossy      (lossy_c),
    ._o_snap       (snap),
    ._o_snap_lossy (snap_lossy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Independent arithmetic model: compare signed values of input and truncation.
  function automatic exp_t model(input logic [IN_W-1:0] v);
    exp_t e;
    logic [TRUNC_W-1:0] t;
    int sv;
    int st;
    t       = v[TRUNC_W-1:0];
    sv      = int'($signed(v));
    st      = int'($signed(t));
    e.out   = {16'($signed(v)), t};
    e.lossy = (sv != st);
    return e;
  endfunction

  task automatic apply(input string tag, input logic [IN_W-1:0] v, input exp_t e);
    exp_t got;
    @(negedge clk);
    inval = v;
    comb_q.push_back(e);
    #1;
    got = comb_q.pop_front();
    chk({tag, "_out"}, out_c, got.out);
    chk({tag, "_lossy"}, {{(OUT_W-1){1'b0}}, lossy_c}, {{(OUT_W-1){1'b0}}, got.lossy});
    snap_q.push_back(got);
    @(negedge clk);
    got = snap_q.pop_front();
    chk({tag, "_snap"}, snap, got.out);
    chk({tag, "_snap_lossy"}, {{(OUT_W-1){1'b0}}, snap_lossy}, {{(OUT_W-1){1'b0}}, got.lossy});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    logic [IN_W-1:0] r;
    checks = 0;
    errors = 0;

    rst_n = 1'b0;
    inval = 8'h8A;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_snap", snap, 20'h00000);
    chk("rst_snap_lossy", {19'd0, snap_lossy}, 20'h00000);
    chk("rst_out", out_c, 20'hFF8AA);
    chk("rst_lossy", {19'd0, lossy_c}, 20'h00001);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_snap", snap, 20'hFF8AA);
    chk("rel_snap_lossy", {19'd0, snap_lossy}, 20'h00001);

    e.out = 20'h00011; e.lossy = 1'b0; apply("v01", 8'h01, e);
    e.out = 20'hFFFFF; e.lossy = 1'b0; apply("vFF", 8'hFF, e);
    e.out = 20'hFF8AA; e.lossy = 1'b1; apply("v8A", 8'b1000_1010, e);
    e.out = 20'h00000; e.lossy = 1'b0; apply("v00", 8'h00, e);
    e.out = 20'hFF800; e.lossy = 1'b1; apply("v80", 8'h80, e);
    e.out = 20'h00077; e.lossy = 1'b0; apply("v07", 8'h07, e);
    e.out = 20'hFFF88; e.lossy = 1'b0; apply("vF8", 8'hF8, e);

    for (int i = 0; i < 8; i++) begin
      r = 8'($urandom_range(0, 255));
      apply("rand", r, model(r));
    end

    e.out = 20'h007FF; e.lossy = 1'b1; apply("v7F", 8'h7F, e);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_snap", snap, 20'h00000);
    chk("async_snap_lossy", {19'd0, snap_lossy}, 20'h00000);
    chk("async_out", out_c, 20'h007FF);
    chk("async_lossy", {19'd0, lossy_c}, 20'h00001);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_snap", snap, 20'h007FF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_width_converter.md
Name: int_width_converter

Overview:
- Signed-integer width-conversion block.
- Takes one two's-complement input word and produces, combinationally, a sign-extended wider copy and a truncated narrower copy.
- Also provides a registered snapshot of both results and a truncation-lossy flag for downstream datapath/debug logic.
- Used wherever a narrow signed field must be widened or narrowed without an extra pipeline stage.

Parameters:
- IN_W, 8, width of the signed input word.
- EXT_W, 16, width of the sign-extended result; must be >= IN_W.
- TRUNC_W, 4, width of the truncated result; must be >= 1 and <= IN_W.

Ports:
- _i_clk  input  1  clock; used only by the snapshot registers.
- _i_rst_n  input  1  asynchronous active-low reset.
- _i_inval  input  IN_W  signed two's-complement input value.
- __output  output  EXT_W+TRUNC_W  combinational concatenation {extended, truncated}; extended occupies the MSBs [EXT_W+TRUNC_W-1:TRUNC_W], truncated the LSBs [TRUNC_W-1:0].
- _o_lossy  output  1  combinational: high when truncation changed the signed value.
- _o_snap  output  EXT_W+TRUNC_W  registered copy of __output.
- _o_snap_lossy  output  1  registered copy of _o_lossy.

Behaviour:
- One clock (_i_clk); reset is asynchronous and active-low (_i_rst_n).
- Extended result:
  - extended = _i_inval sign-extended to EXT_W bits.
  - Bits [IN_W-1:0] equal _i_inval; bits [EXT_W-1:IN_W] all equal _i_inval[IN_W-1].
  - When EXT_W == IN_W, extended equals _i_inval.
- Truncated result:
  - truncated = _i_inval[TRUNC_W-1:0].
  - Upper bits are discarded with no rounding or saturation.
- Lossy flag:
  - _o_lossy = 1 iff _i_inval differs from the sign extension of truncated back to IN_W bits.
  - Equivalently, bits [IN_W-1:TRUNC_W-1] of _i_inval are not all equal.
- __output and _o_lossy are purely combinational:
  - zero-cycle latency;
  - independent of _i_clk and _i_rst_n;
  - valid during reset;
  - settle within the same delta/time step as any _i_inval change.
- Snapshot registers:
  - _o_snap and _o_snap_lossy load __output and _o_lossy on every rising edge of _i_clk.
  - No enable input.
  - Latency is exactly 1 cycle.
- Reset:
  - While _i_rst_n is low, _o_snap = 0 and _o_snap_lossy = 0, asynchronously and immediately, including when asserted mid-operation.
  - The first load occurs on the first rising edge after _i_rst_n goes high.
- Boundary values (IN_W=8):
  - 8'h80: extended 16'hFF80, truncated 4'h0, lossy 1.
  - 8'h7F: extended 16'h007F, truncated 4'hF, lossy 1.
  - 8'h00: all results 0, lossy 0.
- X/undefined input propagates as X to the combinational outputs; no special handling.

Test Plan:
- _i_inval=8'h01 -> extended=16'h0001, truncated=4'h1, _o_lossy=0, same time step.
- _i_inval=8'hFF (-1) -> extended=16'hFFFF, truncated=4'hF, _o_lossy=0.
- _i_inval=8'b1000_1010 -> truncated=4'b1010, extended=16'b1111_1111_1000_1010, _o_lossy=1.
- _i_inval=8'h80 then 8'h7F -> extended 16'hFF80 / 16'h007F, truncated 4'h0 / 4'hF, _o_lossy=1 both.
- Hold _i_rst_n=0 with _i_inval=8'h8A, toggle _i_clk -> _o_snap=0, _o_snap_lossy=0, while __output=20'hFF8AA. Release reset; after one rising edge -> _o_snap=20'hFF8AA, _o_snap_lossy=1.
- Assert _i_rst_n low between clock edges while _o_snap is nonzero -> _o_snap clears immediately without a clock edge; __output is unaffected.
